// File: rtl/vme_reg_bank.sv
// vme_reg_bank: a small VME-mapped bank of NREGS registers, each DATA_W bits wide.
// Requests are captured in an input stage at edge E0 and serviced at E1.
// The acknowledge is high for the cycle that follows E1.
// While a request is outstanding, any new request is ignored.
// When read and write arrive together, the write is serviced first and the read one cycle later.
// Optional macro VME_REG_BANK_ERR_EN adds two outputs, VMERdErr and VMEWrErr.
// They flag accesses to unmapped addresses.
module vme_reg_bank #(
   parameter int NREGS  = 4,
   parameter int DATA_W = 8,
   parameter logic [NREGS*DATA_W-1:0] RESET_VAL = {(NREGS*DATA_W){1'b0}}
) (
   input  logic                    Clk,
   input  logic                    rst_n,
   input  logic [3:0]              VMEAddr,
   input  logic                    VMERdMem,
   input  logic                    VMEWrMem,
   input  logic [31:0]             VMEWrData,
   output logic [31:0]             VMERdData,
   output logic                    VMERdDone,
   output logic                    VMEWrDone,
`ifdef VME_REG_BANK_ERR_EN
   output logic                    VMERdErr,
   output logic                    VMEWrErr,
`endif
   output logic [NREGS*DATA_W-1:0] regs_o,
   output logic [NREGS-1:0]        wr_strb_o
);

   // Input stage. The address and data stay put while a transaction is outstanding.
   // Because of that, a read deferred behind a write still sees its own E0 address.
   logic                    s_rd_q, s_rd_d;
   logic                    s_wr_q, s_wr_d;
   logic [3:0]              s_addr_q, s_addr_d;
   logic [DATA_W-1:0]       s_data_q, s_data_d;
   logic                    pend_rd_q, pend_rd_d;

   logic [NREGS*DATA_W-1:0] regs_q, regs_d;
   logic [31:0]             rd_data_q, rd_data_d;
   logic                    rd_done_q, rd_done_d;
   logic                    wr_done_q, wr_done_d;
   logic [NREGS-1:0]        wr_strb_q, wr_strb_d;
   logic                    rd_err_q, rd_err_d;
   logic                    wr_err_q, wr_err_d;

   logic                    busy_s;
   logic                    rd_go_s;
   logic                    rd_hit_s;
   logic                    wr_hit_s;
   logic [31:0]             rd_word_s;

   // Upper write-data bits are intentionally ignored.
   if (DATA_W < 32) begin : g_unused_data
      logic unused_data_s;
      assign unused_data_s = ^VMEWrData[31:DATA_W];
   end

   // Next-state logic: input capture, register write, and read mux.
   always_comb begin
      s_rd_d    = 1'b0;
      s_wr_d    = 1'b0;
      s_addr_d  = s_addr_q;
      s_data_d  = s_data_q;
      pend_rd_d = 1'b0;
      regs_d    = regs_q;
      rd_data_d = rd_data_q;
      rd_done_d = 1'b0;
      wr_done_d = 1'b0;
      wr_strb_d = {NREGS{1'b0}};
      rd_err_d  = 1'b0;
      wr_err_d  = 1'b0;
      rd_hit_s  = 1'b0;
      wr_hit_s  = 1'b0;
      rd_word_s = 32'h0000_0000;

      busy_s = s_rd_q | s_wr_q | pend_rd_q;
      if (!busy_s) begin
         s_rd_d   = VMERdMem;
         s_wr_d   = VMEWrMem;
         s_addr_d = VMEAddr;
         s_data_d = VMEWrData[DATA_W-1:0];
      end else begin
         s_rd_d = 1'b0;
         s_wr_d = 1'b0;
      end

      // A read that arrives together with a write waits one cycle behind that write.
      if (s_rd_q && s_wr_q) begin
         pend_rd_d = 1'b1;
      end else begin
         pend_rd_d = 1'b0;
      end
      rd_go_s = (s_rd_q & ~s_wr_q) | pend_rd_q;

      for (int i = 0; i < NREGS; i++) begin
         if (s_addr_q == 4'(i)) begin
            rd_hit_s = 1'b1;
            rd_word_s[DATA_W-1:0] = regs_q[i*DATA_W +: DATA_W];
            if (s_wr_q) begin
               wr_hit_s = 1'b1;
               regs_d[i*DATA_W +: DATA_W] = s_data_q;
               wr_strb_d[i] = 1'b1;
            end else begin
               wr_hit_s = wr_hit_s;
            end
         end else begin
            rd_hit_s = rd_hit_s;
         end
      end

      wr_done_d = s_wr_q;
      wr_err_d  = s_wr_q & ~wr_hit_s;

      if (rd_go_s) begin
         rd_done_d = 1'b1;
         rd_data_d = rd_word_s;
         rd_err_d  = ~rd_hit_s;
      end else begin
         rd_done_d = 1'b0;
         rd_data_d = rd_data_q;
         rd_err_d  = 1'b0;
      end
   end

   // State register: the reset clears all pipeline state and aborts any transaction in flight.
   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         s_rd_q    <= 1'b0;
         s_wr_q    <= 1'b0;
         s_addr_q  <= 4'h0;
         s_data_q  <= {DATA_W{1'b0}};
         pend_rd_q <= 1'b0;
         regs_q    <= RESET_VAL;
         rd_data_q <= 32'h0000_0000;
         rd_done_q <= 1'b0;
         wr_done_q <= 1'b0;
         wr_strb_q <= {NREGS{1'b0}};
         rd_err_q  <= 1'b0;
         wr_err_q  <= 1'b0;
      end else begin
         s_rd_q    <= s_rd_d;
         s_wr_q    <= s_wr_d;
         s_addr_q  <= s_addr_d;
         s_data_q  <= s_data_d;
         pend_rd_q <= pend_rd_d;
         regs_q    <= regs_d;
         rd_data_q <= rd_data_d;
         rd_done_q <= rd_done_d;
         wr_done_q <= wr_done_d;
         wr_strb_q <= wr_strb_d;
         rd_err_q  <= rd_err_d;
         wr_err_q  <= wr_err_d;
      end
   end

   assign VMERdData = rd_data_q;
   assign VMERdDone = rd_done_q;
   assign VMEWrDone = wr_done_q;
   assign regs_o    = regs_q;
   assign wr_strb_o = wr_strb_q;

`ifdef VME_REG_BANK_ERR_EN
   assign VMERdErr = rd_err_q;
   assign VMEWrErr = wr_err_q;
`else
   // Error flags are not exported in this build.
   logic unused_err_s;
   assign unused_err_s = rd_err_q ^ wr_err_q;
`endif

endmodule

// File: doc/vme_reg_bank.md
VME_REG_BANK -- requirements
Module: vme_reg_bank

Interface
REQ-001 Parameter NREGS, default 4, number of registers (1..16).
REQ-002 Parameter DATA_W, default 8, register width in bits (1..32).
REQ-003 Parameter RESET_VAL, default all zeros, NREGS*DATA_W bits; register i resets to slice [i*DATA_W +: DATA_W].
REQ-004 Clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 VMEAddr  in  4  word address; values >= NREGS are unmapped.
REQ-007 VMERdMem  in  1  read request pulse.
REQ-008 VMEWrMem  in  1  write request pulse.
REQ-009 VMEWrData  in  32  write data.
REQ-010 VMERdData  out  32  read data, valid while VMERdDone=1.
REQ-011 VMERdDone  out  1  one-cycle read acknowledge.
REQ-012 VMEWrDone  out  1  one-cycle write acknowledge.
REQ-013 regs_o  out  NREGS*DATA_W  register contents, register i at [i*DATA_W +: DATA_W].
REQ-014 wr_strb_o  out  NREGS  one-cycle pulse on bit i when register i is written.

Function
REQ-015 The block SHALL sample VMEAddr, VMEWrData, VMERdMem and VMEWrMem into an input pipeline stage at every edge (edge E0).
REQ-016 Write: the addressed register SHALL load VMEWrData[DATA_W-1:0] at E1; VMEWrDone and wr_strb_o[i] SHALL be high for exactly the cycle following E1.
REQ-017 Read: VMERdData SHALL be registered at E1 from the addressed register, zero-extended to 32 bits (never X); VMERdDone SHALL be high for exactly the cycle following E1.
REQ-018 Read-after-write to the same register SHALL return the new value when the read is sampled at or after E1 of the write.
REQ-019 VMERdData SHALL hold its last value between acknowledges.
REQ-020 A request sampled while a transaction is outstanding (between its E0 and its acknowledge cycle) SHALL be dropped with no acknowledge.
REQ-021 VMERdMem and VMEWrMem sampled high together: write SHALL be serviced first; the read, with its address latched at E0, SHALL be serviced next, VMERdDone one cycle after VMEWrDone.
REQ-022 Unmapped write SHALL change no register, pulse no wr_strb_o bit, and still acknowledge with standard latency.
REQ-023 Unmapped read SHALL return 32'h0 and acknowledge with standard latency.
REQ-024 Data bits VMEWrData[31:DATA_W] SHALL be ignored.

Reset
REQ-025 On rst_n low, immediately and independent of Clk: registers to RESET_VAL, VMERdData to 0, VMERdDone, VMEWrDone, wr_strb_o, error outputs and all pipeline/pending state to 0.
REQ-026 Reset mid-transaction SHALL abort it: no acknowledge after reset release and no register update.
REQ-027 First request SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro VME_REG_BANK_ERR_EN defined: outputs VMERdErr and VMEWrErr (1 bit each) SHALL exist and pulse coincident with VMERdDone/VMEWrDone for unmapped accesses; reset value 0.
REQ-029 Macro undefined: those ports and their logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 NREGS=4, DATA_W=8: write 32'hDEADBEEF to addr 2 -> VMEWrDone and wr_strb_o=4'b0100 two cycles after request; regs_o[23:16]=8'hEF.
REQ-031 Read addr 2 after REQ-030 -> VMERdDone two cycles after request, VMERdData=32'h000000EF.
REQ-032 VMERdMem and VMEWrMem together, addr 1, data 8'h5A -> VMEWrDone at cycle +2, VMERdDone at cycle +3 with VMERdData=32'h0000005A.
REQ-033 Read addr 7 with VME_REG_BANK_ERR_EN defined -> VMERdData=0, VMERdDone and VMERdErr high together; write addr 7 -> no regs_o change, VMEWrErr high.
REQ-034 Second write pulse one cycle after the first -> only one VMEWrDone; only the first write takes effect.
REQ-035 rst_n low one cycle after a write request -> no VMEWrDone; regs_o equals RESET_VAL immediately.
